// File: rtl/hovalaag_io_bridge.sv
// Host-side bridge for the Hovalaag core: chunked instr/IN assembly, IN1/IN2/OUT FIFOs
// and gated single-step issue. Define HOVALAAG_BRIDGE_SEG7_EN for the sel-3 seven-segment readback.

module hovalaag_io_bridge_fifo #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign head  = empty ? '0 : mem_q[rd_q];

    // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) rd_d = rd_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        if (clear) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module hovalaag_io_bridge #(
    parameter int unsigned IO_WIDTH    = 6,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned IN_DEPTH    = 4,
    parameter int unsigned OUT_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_valid,
    input  logic [2:0]             host_cmd,
    input  logic [IO_WIDTH-1:0]    host_data,
    input  logic [1:0]             host_rd_sel,
    output logic [7:0]             host_rd_data,
    output logic [INSTR_WIDTH-1:0] core_instr,
    output logic [DATA_WIDTH-1:0]  core_in1,
    output logic [DATA_WIDTH-1:0]  core_in2,
    output logic                   core_step,
    input  logic                   core_in1_adv,
    input  logic                   core_in2_adv,
    input  logic [DATA_WIDTH-1:0]  core_out,
    input  logic                   core_out_valid,
    input  logic                   core_out_sel
);
    localparam int unsigned NCHUNK = (DATA_WIDTH + IO_WIDTH - 1) / IO_WIDTH;
    localparam int unsigned ASM_W  = NCHUNK * IO_WIDTH;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [2:0] {
        CMD_INSTR   = 3'd0,
        CMD_IN1     = 3'd1,
        CMD_IN2     = 3'd2,
        CMD_EXEC    = 3'd3,
        CMD_OUT_POP = 3'd4,
        CMD_CLEAR   = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_STEP
    } state_e;

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   ovf_q, ovf_d;
    logic [ASM_W-1:0]       asm_q [2];
    logic [ASM_W-1:0]       asm_d [2];
    logic [CNT_W-1:0]       chunk_cnt_q [2];
    logic [CNT_W-1:0]       chunk_cnt_d [2];
    logic [DATA_WIDTH-1:0]  in_word [2];
    logic [DATA_WIDTH-1:0]  in_head [2];
    logic [1:0]             in_push, in_pop, in_full, in_empty;
    logic [DATA_WIDTH:0]    out_head;
    logic                   out_push, out_pop, out_full, out_empty;
    logic                   exec_cmd, clear, drop, busy, ok;
    logic [7:0]             rd_sel3;

    assign exec_cmd = host_valid && (host_cmd == CMD_EXEC);
    assign clear    = host_valid && (host_cmd == CMD_CLEAR) && (state_q == S_IDLE);
    assign out_pop  = host_valid && (host_cmd == CMD_OUT_POP);

    // Chunks shift in from the top, so after NCHUNK chunks the first one sits in the LSBs.
    always_comb begin
        drop = 1'b0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            asm_d[ch]       = asm_q[ch];
            chunk_cnt_d[ch] = chunk_cnt_q[ch];
            in_push[ch]     = 1'b0;
            if (host_valid && (host_cmd == ((ch == 0) ? CMD_IN1 : CMD_IN2))) begin
                asm_d[ch] = (asm_q[ch] >> IO_WIDTH) | (ASM_W'(host_data) << (ASM_W - IO_WIDTH));
                if (chunk_cnt_q[ch] == CNT_W'(NCHUNK - 1)) begin
                    chunk_cnt_d[ch] = '0;
                    in_push[ch]     = 1'b1;
                    if (in_full[ch] && !in_pop[ch]) drop = 1'b1;
                end else begin
                    chunk_cnt_d[ch] = chunk_cnt_q[ch] + 1'b1;
                end
            end
            if (clear) chunk_cnt_d[ch] = '0;
            in_word[ch] = asm_d[ch][DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        ovf_d = ovf_q | drop;
        if (clear) ovf_d = 1'b0;
        instr_d = instr_q;
        if (host_valid && (host_cmd == CMD_INSTR) && (state_q == S_IDLE))
            instr_d = INSTR_WIDTH'({instr_q, host_data});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                asm_q[ch]       <= '0;
                chunk_cnt_q[ch] <= '0;
            end
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ovf_q   <= ovf_d;
            asm_q   <= asm_d;
            chunk_cnt_q <= chunk_cnt_d;
        end
    end

    assign ok = !(core_in1_adv && in_empty[0]) && !(core_in2_adv && in_empty[1])
             && !(core_out_valid && out_full);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (exec_cmd) state_d = S_PENDING;
            S_PENDING: if (ok) state_d = S_STEP;
            S_STEP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        core_step = (state_q == S_STEP);
        busy      = (state_q != S_IDLE);
        in_pop    = {core_step && core_in2_adv, core_step && core_in1_adv};
        out_push  = core_step && core_out_valid;
    end

    hovalaag_io_bridge_fifo #(.W(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in1_fifo (
        .clk(clk), .reset(reset), .clear(clear), .push(in_push[0]), .wdata(in_word[0]),
        .pop(in_pop[0]), .head(in_head[0]), .full(in_full[0]), .empty(in_empty[0])
    );

    hovalaag_io_bridge_fifo #(.W(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in2_fifo (
        .clk(clk), .reset(reset), .clear(clear), .push(in_push[1]), .wdata(in_word[1]),
        .pop(in_pop[1]), .head(in_head[1]), .full(in_full[1]), .empty(in_empty[1])
    );

    hovalaag_io_bridge_fifo #(.W(DATA_WIDTH + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(clk), .reset(reset), .clear(clear), .push(out_push), .wdata({core_out_sel, core_out}),
        .pop(out_pop), .head(out_head), .full(out_full), .empty(out_empty)
    );

    assign core_instr = instr_q;
    assign core_in1   = in_head[0];
    assign core_in2   = in_head[1];

`ifdef HOVALAAG_BRIDGE_SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    seg7 = 7'h3F;
            4'h1:    seg7 = 7'h06;
            4'h2:    seg7 = 7'h5B;
            4'h3:    seg7 = 7'h4F;
            4'h4:    seg7 = 7'h66;
            4'h5:    seg7 = 7'h6D;
            4'h6:    seg7 = 7'h7D;
            4'h7:    seg7 = 7'h07;
            4'h8:    seg7 = 7'h7F;
            4'h9:    seg7 = 7'h6F;
            4'hA:    seg7 = 7'h77;
            4'hB:    seg7 = 7'h7C;
            4'hC:    seg7 = 7'h39;
            4'hD:    seg7 = 7'h5E;
            4'hE:    seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    assign rd_sel3 = out_empty ? '0 : {out_head[DATA_WIDTH], seg7(out_head[3:0])};
`else
    assign rd_sel3 = '0;
`endif

    // The output head is already forced to zero when empty, so sel 1/2 read 0 for free.
    always_comb begin
        host_rd_data = '0;
        case (host_rd_sel)
            2'd0:    host_rd_data = {ovf_q, busy, out_full, out_empty,
                                     in_full[1], in_empty[1], in_full[0], in_empty[0]};
            2'd1:    host_rd_data = out_head[7:0];
            2'd2:    host_rd_data = {out_head[DATA_WIDTH], 7'(out_head[DATA_WIDTH-1:8])};
            default: host_rd_data = rd_sel3;
        endcase
    end
endmodule

// File: tb/tb_hovalaag_io_bridge.sv
// Scoreboard bench for hovalaag_io_bridge: queue-based reference model, randomized host traffic,
// and a monitor that checks every core_step against the expected step records.
`timescale 1ns/1ps
module tb_hovalaag_io_bridge;
    localparam int IOW = 6;
    localparam int IW  = 32;
    localparam int DW  = 12;
    localparam int ID  = 4;
    localparam int OD  = 4;
    localparam int NCH = (DW + IOW - 1) / IOW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          host_valid = 1'b0;
    logic [2:0]    host_cmd = '0;
    logic [IOW-1:0] host_data = '0;
    logic [1:0]    host_rd_sel = '0;
    logic [7:0]    host_rd_data;
    logic [IW-1:0] core_instr;
    logic [DW-1:0] core_in1, core_in2;
    logic          core_step;
    logic          core_in1_adv = 1'b0, core_in2_adv = 1'b0;
    logic [DW-1:0] core_out = '0;
    logic          core_out_valid = 1'b0, core_out_sel = 1'b0;

    hovalaag_io_bridge #(
        .IO_WIDTH(IOW), .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)
    ) dut (
        .clk(clk), .reset(reset), .host_valid(host_valid), .host_cmd(host_cmd),
        .host_data(host_data), .host_rd_sel(host_rd_sel), .host_rd_data(host_rd_data),
        .core_instr(core_instr), .core_in1(core_in1), .core_in2(core_in2),
        .core_step(core_step), .core_in1_adv(core_in1_adv), .core_in2_adv(core_in2_adv),
        .core_out(core_out), .core_out_valid(core_out_valid), .core_out_sel(core_out_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain queues, the sticky overflow flag and the instruction word.
    int          q1[$];
    int          q2[$];
    int          qo[$];
    bit          m_ovf;
    logic [31:0] m_instr;

    typedef struct {
        int cyc;
        bit chk1;
        bit chk2;
        int in1;
        int in2;
    } step_t;
    step_t sb[$];
    step_t mrec;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (core_step) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_step: core_step=1 with no step expected (cycle %0d)", cyc);
            end else begin
                mrec = sb.pop_front();
                check("step_cycle", cyc, mrec.cyc);
                if (mrec.chk1) check("step_in1", int'(core_in1), mrec.in1);
                if (mrec.chk2) check("step_in2", int'(core_in2), mrec.in2);
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            mrec = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_step: core_step=0 expected 1 by cycle %0d (now %0d)", mrec.cyc, cyc);
        end
    end

    function automatic int exp_status();
        logic [7:0] s;
        s = {m_ovf, 1'b0, qo.size() == OD, qo.size() == 0,
             q2.size() == ID, q2.size() == 0, q1.size() == ID, q1.size() == 0};
        return int'(s);
    endfunction

    function automatic int exp_sel1();
        if (qo.size() == 0) return 0;
        return qo[0] & 'hFF;
    endfunction

    function automatic int exp_sel2();
        if (qo.size() == 0) return 0;
        return (((qo[0] >> DW) & 1) << 7) | ((qo[0] >> 8) & ((1 << (DW - 8)) - 1));
    endfunction

`ifdef HOVALAAG_BRIDGE_SEG7_EN
    int seg_tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                        'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
    function automatic int exp_sel3();
        if (qo.size() == 0) return 0;
        return (((qo[0] >> DW) & 1) << 7) | seg_tab[qo[0] & 15];
    endfunction
`else
    function automatic int exp_sel3();
        return 0;
    endfunction
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input int s, output int v);
        host_rd_sel = 2'(s);
        #1;
        v = int'(host_rd_data);
    endtask

    task automatic cmd(input int c, input int d);
        host_valid = 1'b1;
        host_cmd   = 3'(c);
        host_data  = IOW'(d);
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        host_cmd   = '0;
        host_data  = '0;
    endtask

    task automatic verify(input string tag);
        int v;
        rd(0, v); check({tag, "_status"}, v, exp_status());
        rd(1, v); check({tag, "_sel1"}, v, exp_sel1());
        rd(2, v); check({tag, "_sel2"}, v, exp_sel2());
        rd(3, v); check({tag, "_sel3"}, v, exp_sel3());
        check({tag, "_in1"}, int'(core_in1), (q1.size() != 0) ? q1[0] : 0);
        check({tag, "_in2"}, int'(core_in2), (q2.size() != 0) ? q2[0] : 0);
        check({tag, "_instr"}, int'(core_instr), int'(m_instr));
    endtask

    task automatic model_clear();
        q1.delete();
        q2.delete();
        qo.delete();
        m_ovf = 1'b0;
    endtask

    task automatic push_word(input int ch, input int w);
        for (int k = 0; k < NCH; k++) cmd(ch + 1, (w >> (k * IOW)) & ((1 << IOW) - 1));
        if (ch == 0) begin
            if (q1.size() < ID) q1.push_back(w); else m_ovf = 1'b1;
        end else begin
            if (q2.size() < ID) q2.push_back(w); else m_ovf = 1'b1;
        end
    endtask

    task automatic instr_chunk(input int d);
        cmd(0, d);
        m_instr = (m_instr << IOW) | 32'(d);
    endtask

    task automatic set_core(input bit a1, input bit a2, input bit ov, input bit os, input int oval);
        core_in1_adv   = a1;
        core_in2_adv   = a2;
        core_out_valid = ov;
        core_out_sel   = os;
        core_out       = DW'(oval);
    endtask

    // Called right after the sampling edge of the event that lets the step go: step is due next cycle.
    task automatic expect_step(input bit a1, input bit a2, input bit ov, input bit os, input int oval);
        step_t r;
        int    dummy;
        r.cyc  = cyc + 1;
        r.chk1 = a1;
        r.chk2 = a2;
        r.in1  = a1 ? q1[0] : 0;
        r.in2  = a2 ? q2[0] : 0;
        if (a1) dummy = q1.pop_front();
        if (a2) dummy = q2.pop_front();
        if (ov) qo.push_back((int'(os) << DW) | oval);
        sb.push_back(r);
    endtask

    task automatic exec_step(input bit a1, input bit a2, input bit ov, input bit os, input int oval);
        set_core(a1, a2, ov, os, oval);
        cmd(3, 0);
        expect_step(a1, a2, ov, os, oval);
        tick(2);
        set_core(0, 0, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int v, w, op, dummy;
        bit a1, a2, ov;
        model_clear();
        m_instr = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_step", int'(core_step), 0);
        reset = 1'b0;
        verify("reset");
        rd(0, v); check("reset_status_const", v, 'h15);

        for (int i = 0; i < 6; i++) instr_chunk($urandom_range(0, 63));
        verify("instr");

        push_word(0, 'hA85);
        check("in1_assembled", int'(core_in1), 'hA85);
        verify("in1_word");

        exec_step(1, 0, 0, 0, 0);
        verify("in1_consumed");

        // IN1 starved: EXEC parks in PENDING until a word lands.
        set_core(1, 0, 0, 0, 0);
        cmd(3, 0);
        tick(10);
        rd(0, v); check("stall_in1_busy", v, exp_status() | 'h40);
        push_word(0, 'h123);
        expect_step(1, 0, 0, 0, 0);
        tick(2);
        set_core(0, 0, 0, 0, 0);
        verify("stall_in1_done");

        exec_step(0, 0, 1, 1, 'hABC);
        rd(1, v); check("out_sel1_const", v, 'hBC);
        rd(2, v); check("out_sel2_const", v, 'h8A);
`ifdef HOVALAAG_BRIDGE_SEG7_EN
        rd(3, v); check("out_sel3_const", v, 'hB9);
`else
        rd(3, v); check("out_sel3_const", v, 0);
`endif
        verify("out_written");
        cmd(4, 0);
        dummy = qo.pop_front();
        verify("out_popped");

        for (int i = 0; i < ID + 1; i++) push_word(1, $urandom_range(0, (1 << DW) - 1));
        verify("in2_overflow");
        rd(0, v); check("ovf_flag", (v >> 7) & 1, 1);
        cmd(5, 0);
        model_clear();
        verify("clear");
        rd(0, v); check("clear_status_const", v, 'h15);

        // Full IN1: last chunk lands in the same cycle the step pops.
        for (int i = 0; i < ID; i++) push_word(0, $urandom_range(0, (1 << DW) - 1));
        set_core(1, 0, 0, 0, 0);
        cmd(3, 0);
        expect_step(1, 0, 0, 0, 0);
        push_word(0, $urandom_range(0, (1 << DW) - 1));
        set_core(0, 0, 0, 0, 0);
        verify("full_push_pop");
        cmd(5, 0);
        model_clear();

        // Full output FIFO: step stalls until the host pops, new entry goes last.
        for (int i = 0; i < OD; i++)
            exec_step(0, 0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, (1 << DW) - 1));
        verify("out_full");
        set_core(0, 0, 1, 1, 'h5A5);
        cmd(3, 0);
        tick(6);
        rd(0, v); check("stall_out_busy", v, exp_status() | 'h40);
        cmd(4, 0);
        dummy = qo.pop_front();
        expect_step(0, 0, 1, 1, 'h5A5);
        tick(2);
        set_core(0, 0, 0, 0, 0);
        verify("stall_out_done");
        for (int i = 0; i < OD; i++) begin
            verify("out_drain");
            cmd(4, 0);
            dummy = qo.pop_front();
        end
        verify("out_drained");

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 9: push_word($urandom_range(0, 1), $urandom_range(0, (1 << DW) - 1));
                3, 4: begin
                    a1 = (q1.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    a2 = (q2.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    ov = (qo.size() < OD) ? 1'($urandom_range(0, 1)) : 1'b0;
                    exec_step(a1, a2, ov, 1'($urandom_range(0, 1)), $urandom_range(0, (1 << DW) - 1));
                end
                5: begin
                    cmd(4, 0);
                    if (qo.size() != 0) dummy = qo.pop_front();
                end
                6: instr_chunk($urandom_range(0, 63));
                7: cmd($urandom_range(6, 7), $urandom_range(0, 63));
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        cmd(5, 0);
                        model_clear();
                    end else begin
                        cmd(4, 0);
                        if (qo.size() != 0) dummy = qo.pop_front();
                    end
                end
            endcase
            verify("rand");
        end

        // Reset while PENDING aborts the step.
        cmd(5, 0);
        model_clear();
        set_core(1, 0, 0, 0, 0);
        cmd(3, 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        set_core(0, 0, 0, 0, 0);
        model_clear();
        m_instr = '0;
        tick(3);
        verify("reset_pending");

        // Reset on the edge that would enter STEP: no step, FIFO emptied by reset.
        push_word(0, $urandom_range(0, (1 << DW) - 1));
        set_core(1, 0, 0, 0, 0);
        cmd(3, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        set_core(0, 0, 0, 0, 0);
        model_clear();
        tick(3);
        verify("reset_step");

        tick(3);
        check("steps_outstanding", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
